// File: rtl/rs_branch_multi.sv
// Branch reservation station: DEPTH entries, CDB wakeup with alloc bypass, oldest-ready issue.
// Latency 1 cycle alloc/wakeup to issue_valid; issue held under issue_ready=0, alloc refused when full.
module rs_branch_multi #(
  parameter int DEPTH    = 4,
  parameter int CH       = 4,
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter int OP_W     = 6,
  parameter int UNLOCKED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      alloc_en,
  input  logic [XLEN-1:0]           alloc_pc,
  input  logic [OP_W-1:0]           alloc_op,
  input  logic [XLEN-1:0]           alloc_imm,
  input  logic [TAG_W-1:0]          alloc_tagx,
  input  logic [TAG_W-1:0]          alloc_tagy,
  input  logic [XLEN-1:0]           alloc_datax,
  input  logic [XLEN-1:0]           alloc_datay,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  input  logic [CH-1:0]             cdb_en,
  input  logic [CH*TAG_W-1:0]       cdb_tag,
  input  logic [CH*XLEN-1:0]        cdb_data,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [XLEN-1:0]           issue_pc,
  output logic [XLEN-1:0]           issue_imm,
  output logic [XLEN-1:0]           issue_datax,
  output logic [XLEN-1:0]           issue_datay,
  output logic [OP_W-1:0]           issue_op,
  input  logic                      flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TAG_W-1:0] UNL = TAG_W'(UNLOCKED);

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [XLEN-1:0]   pc_q    [DEPTH];
  logic [XLEN-1:0]   pc_d    [DEPTH];
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [OP_W-1:0]   op_d    [DEPTH];
  logic [XLEN-1:0]   imm_q   [DEPTH];
  logic [XLEN-1:0]   imm_d   [DEPTH];
  logic [TAG_W-1:0]  tagx_q  [DEPTH];
  logic [TAG_W-1:0]  tagx_d  [DEPTH];
  logic [TAG_W-1:0]  tagy_q  [DEPTH];
  logic [TAG_W-1:0]  tagy_d  [DEPTH];
  logic [XLEN-1:0]   datax_q [DEPTH];
  logic [XLEN-1:0]   datax_d [DEPTH];
  logic [XLEN-1:0]   datay_q [DEPTH];
  logic [XLEN-1:0]   datay_d [DEPTH];
  logic [AW-1:0]     age_q   [DEPTH];
  logic [AW-1:0]     age_d   [DEPTH];

  logic [CW-1:0] cnt;
  logic          sel_found;
  logic [AW-1:0] sel_idx;
  logic [AW-1:0] sel_age;
  logic [AW-1:0] free_idx;
  logic          alloc_fire;
  logic          issue_fire;
  logic [XLEN:0] hx, hy;

  // Returns {hit, data}; lowest channel index wins, UNLOCKED never matches.
  function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] t,
                                          input logic [CH-1:0] en,
                                          input logic [CH*TAG_W-1:0] tags,
                                          input logic [CH*XLEN-1:0] data);
    logic [XLEN:0] r;
    r = '0;
    for (int c = CH - 1; c >= 0; c--) begin
      if (en[c] && t != UNL && tags[c*TAG_W +: TAG_W] == t) r = {1'b1, data[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  always_comb begin
    cnt       = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      cnt = cnt + CW'(valid_q[i]);
      if (!valid_q[i]) free_idx = AW'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tagx_q[i] == UNL && tagy_q[i] == UNL &&
          (!sel_found || age_q[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = AW'(i);
        sel_age   = age_q[i];
      end
    end
  end

  assign count       = cnt;
  assign full        = (cnt == CW'(DEPTH));
  assign issue_valid = rdy & sel_found;
  assign issue_fire  = issue_valid & issue_ready;
  assign alloc_fire  = alloc_en & rdy & ~full & ~flush;
  assign issue_pc    = issue_valid ? pc_q[sel_idx]    : '0;
  assign issue_imm   = issue_valid ? imm_q[sel_idx]   : '0;
  assign issue_datax = issue_valid ? datax_q[sel_idx] : '0;
  assign issue_datay = issue_valid ? datay_q[sel_idx] : '0;
  assign issue_op    = issue_valid ? op_q[sel_idx]    : '0;

  always_comb begin
    hx = '0;
    hy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      pc_d[i]    = pc_q[i];
      op_d[i]    = op_q[i];
      imm_d[i]   = imm_q[i];
      tagx_d[i]  = tagx_q[i];
      tagy_d[i]  = tagy_q[i];
      datax_d[i] = datax_q[i];
      datay_d[i] = datay_q[i];
      age_d[i]   = age_q[i];
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          hx = snoop(tagx_q[i], cdb_en, cdb_tag, cdb_data);
          hy = snoop(tagy_q[i], cdb_en, cdb_tag, cdb_data);
          if (hx[XLEN]) begin
            tagx_d[i]  = UNL;
            datax_d[i] = hx[XLEN-1:0];
          end
          if (hy[XLEN]) begin
            tagy_d[i]  = UNL;
            datay_d[i] = hy[XLEN-1:0];
          end
          // Older-than-issued entries step down, so ages stay dense across alloc+issue.
          if (issue_fire && AW'(i) == sel_idx) valid_d[i] = 1'b0;
          else age_d[i] = age_q[i] + AW'(alloc_fire) - AW'(issue_fire && age_q[i] > sel_age);
        end
      end
      if (alloc_fire) begin
        hx = snoop(alloc_tagx, cdb_en, cdb_tag, cdb_data);
        hy = snoop(alloc_tagy, cdb_en, cdb_tag, cdb_data);
        valid_d[free_idx] = 1'b1;
        pc_d[free_idx]    = alloc_pc;
        op_d[free_idx]    = alloc_op;
        imm_d[free_idx]   = alloc_imm;
        age_d[free_idx]   = '0;
        tagx_d[free_idx]  = hx[XLEN] ? UNL : alloc_tagx;
        datax_d[free_idx] = hx[XLEN] ? hx[XLEN-1:0] : alloc_datax;
        tagy_d[free_idx]  = hy[XLEN] ? UNL : alloc_tagy;
        datay_d[free_idx] = hy[XLEN] ? hy[XLEN-1:0] : alloc_datay;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        valid_q[i] <= 1'b0;
        pc_q[i]    <= '0;
        op_q[i]    <= '0;
        imm_q[i]   <= '0;
        tagx_q[i]  <= UNL;
        tagy_q[i]  <= UNL;
        datax_q[i] <= '0;
        datay_q[i] <= '0;
        age_q[i]   <= '0;
      end else begin
        valid_q[i] <= valid_d[i];
        pc_q[i]    <= pc_d[i];
        op_q[i]    <= op_d[i];
        imm_q[i]   <= imm_d[i];
        tagx_q[i]  <= tagx_d[i];
        tagy_q[i]  <= tagy_d[i];
        datax_q[i] <= datax_d[i];
        datay_q[i] <= datay_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rs_branch_multi.sv
// Directed bench for rs_branch_multi: hand-computed expectations checked 1 time unit after each edge.
module tb_rs_branch_multi;
  logic        clk, rst, rdy, alloc_en, full, cdb_dummy;
  logic [31:0] alloc_pc, alloc_imm, alloc_datax, alloc_datay;
  logic [5:0]  alloc_op;
  logic [3:0]  alloc_tagx, alloc_tagy;
  logic [2:0]  count;
  logic [3:0]  cdb_en;
  logic [15:0] cdb_tag;
  logic [127:0] cdb_data;
  logic        issue_valid, issue_ready, flush;
  logic [31:0] issue_pc, issue_imm, issue_datax, issue_datay;
  logic [5:0]  issue_op;
  int checks = 0;
  int errors = 0;

  rs_branch_multi dut (
    .clk(clk), .rst(rst), .rdy(rdy), .alloc_en(alloc_en), .alloc_pc(alloc_pc),
    .alloc_op(alloc_op), .alloc_imm(alloc_imm), .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy),
    .alloc_datax(alloc_datax), .alloc_datay(alloc_datay), .full(full), .count(count),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_datax(issue_datax), .issue_datay(issue_datay), .issue_op(issue_op), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [3:0] tx, input logic [3:0] ty,
                           input logic [31:0] dx, input logic [31:0] dy);
    alloc_en = 1'b1; alloc_pc = pc; alloc_tagx = tx; alloc_tagy = ty;
    alloc_datax = dx; alloc_datay = dy; alloc_imm = pc + 32'h8; alloc_op = 6'd3;
  endtask

  initial begin
    cdb_dummy = 1'b0;
    rst = 1'b1; rdy = 1'b1; alloc_en = 1'b0; alloc_pc = '0; alloc_op = '0; alloc_imm = '0;
    alloc_tagx = '0; alloc_tagy = '0; alloc_datax = '0; alloc_datay = '0;
    cdb_en = '0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ivalid", 64'(issue_valid), 64'd0);
    chk("rst_ipc", 64'(issue_pc), 64'd0);
    chk("rst_idatax", 64'(issue_datax), 64'd0);

    // Ready alloc issues the next cycle and drains the cycle after
    set_alloc(32'h100, 4'd0, 4'd0, 32'd5, 32'd5);
    issue_ready = 1'b1;
    tick(); alloc_en = 1'b0;
    chk("basic_ivalid", 64'(issue_valid), 64'd1);
    chk("basic_ipc", 64'(issue_pc), 64'h100);
    chk("basic_idatax", 64'(issue_datax), 64'd5);
    chk("basic_iimm", 64'(issue_imm), 64'h108);
    chk("basic_iop", 64'(issue_op), 64'd3);
    chk("basic_count1", 64'(count), 64'd1);
    tick();
    chk("basic_count0", 64'(count), 64'd0);
    chk("basic_ivalid0", 64'(issue_valid), 64'd0);

    // Pending A, ready B; wakeup of A makes it the presented entry
    issue_ready = 1'b0;
    set_alloc(32'h200, 4'd3, 4'd0, 32'd0, 32'd1);
    tick();
    set_alloc(32'h300, 4'd0, 4'd0, 32'd9, 32'd2);
    tick(); alloc_en = 1'b0;
    chk("ab_ivalid", 64'(issue_valid), 64'd1);
    chk("ab_ipc_b", 64'(issue_pc), 64'h300);
    chk("ab_count", 64'(count), 64'd2);
    cdb_en = 4'b0010; cdb_tag = 16'h0030; cdb_data = {32'h0, 32'h0, 32'h77, 32'h0};
    tick(); cdb_en = '0;
    chk("ab_ipc_a", 64'(issue_pc), 64'h200);
    chk("ab_idatax", 64'(issue_datax), 64'h77);
    issue_ready = 1'b1;
    tick();
    chk("ab_after_a_pc", 64'(issue_pc), 64'h300);
    chk("ab_after_a_cnt", 64'(count), 64'd1);
    tick(); issue_ready = 1'b0;
    chk("ab_drained", 64'(count), 64'd0);

    // Fill with pending entries, overfill, then issue+alloc while full
    for (int i = 0; i < 4; i++) begin
      set_alloc(32'h400 + 32'(i * 4), 4'd5, 4'd0, 32'd0, 32'd0);
      tick();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ivalid", 64'(issue_valid), 64'd0);
    set_alloc(32'h4F0, 4'd0, 4'd0, 32'd1, 32'd1);
    tick(); alloc_en = 1'b0;
    chk("overfill_count", 64'(count), 64'd4);
    chk("overfill_ivalid", 64'(issue_valid), 64'd0);
    cdb_en = 4'b0001; cdb_tag = 16'h0005; cdb_data = {96'h0, 32'h55};
    tick(); cdb_en = '0;
    chk("fill_oldest_pc", 64'(issue_pc), 64'h400);
    chk("fill_wake_dx", 64'(issue_datax), 64'h55);
    set_alloc(32'h500, 4'd0, 4'd0, 32'd1, 32'd1);
    issue_ready = 1'b1;
    tick(); alloc_en = 1'b0;
    chk("full_alloc_issue_cnt", 64'(count), 64'd3);
    chk("full_alloc_issue_full", 64'(full), 64'd0);
    chk("full_next_pc", 64'(issue_pc), 64'h404);
    tick();
    chk("drain_pc", 64'(issue_pc), 64'h408);
    tick(); tick(); issue_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);

    // Alloc bypass on channel 2
    cdb_en = 4'b0100; cdb_tag = 16'h0700; cdb_data = {32'h0, 32'hABCD, 32'h0, 32'h0};
    set_alloc(32'h600, 4'd0, 4'd7, 32'd1, 32'd0);
    tick(); alloc_en = 1'b0; cdb_en = '0;
    chk("bypass_ivalid", 64'(issue_valid), 64'd1);
    chk("bypass_idatay", 64'(issue_datay), 64'hABCD);
    // Simultaneous issue and alloc while not full keeps count
    set_alloc(32'h610, 4'd0, 4'd0, 32'd2, 32'd2);
    issue_ready = 1'b1;
    tick(); alloc_en = 1'b0;
    chk("swap_count", 64'(count), 64'd1);
    chk("swap_ipc", 64'(issue_pc), 64'h610);
    tick(); issue_ready = 1'b0;
    chk("swap_drained", 64'(count), 64'd0);

    // Two channels hit the same tag: lowest index wins
    set_alloc(32'h700, 4'd2, 4'd0, 32'd0, 32'd3);
    tick(); alloc_en = 1'b0;
    cdb_en = 4'b1001; cdb_tag = 16'h2002; cdb_data = {32'h22, 32'h0, 32'h0, 32'h11};
    tick(); cdb_en = '0;
    chk("prio_ivalid", 64'(issue_valid), 64'd1);
    chk("prio_idatax", 64'(issue_datax), 64'h11);

    // rdy=0 blocks issue and allocation
    rdy = 1'b0; #1;
    chk("stall_ivalid", 64'(issue_valid), 64'd0);
    set_alloc(32'h710, 4'd0, 4'd0, 32'd0, 32'd0);
    issue_ready = 1'b1;
    tick(); alloc_en = 1'b0; issue_ready = 1'b0;
    chk("stall_count", 64'(count), 64'd1);
    rdy = 1'b1; #1;
    chk("unstall_ipc", 64'(issue_pc), 64'h700);

    // Flush with concurrent alloc
    set_alloc(32'h800, 4'd9, 4'd0, 32'd0, 32'd0);
    tick();
    set_alloc(32'h804, 4'd9, 4'd0, 32'd0, 32'd0);
    tick();
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1;
    set_alloc(32'h808, 4'd0, 4'd0, 32'd0, 32'd0);
    tick(); flush = 1'b0; alloc_en = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ivalid", 64'(issue_valid), 64'd0);
    chk("flush_full", 64'(full), 64'd0);

    // Mid-stream reset
    set_alloc(32'h900, 4'd0, 4'd0, 32'd4, 32'd4);
    tick();
    set_alloc(32'h904, 4'd0, 4'd0, 32'd4, 32'd4);
    tick(); alloc_en = 1'b0;
    chk("pre_rst_ivalid", 64'(issue_valid), 64'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_ivalid", 64'(issue_valid), 64'd0);
    chk("mrst_ipc", 64'(issue_pc), 64'd0);
    chk("mrst_idatax", 64'(issue_datax), 64'd0);
    chk("mrst_full", 64'(full), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rs_branch_multi.md
# rs_branch_multi

Multi-entry reservation station for branch instructions. It replaces the single-slot branch station between the allocator and the branch unit. It holds up to DEPTH branches and wakes up pending operands by snooping CH result-broadcast channels, with same-cycle bypass at allocation. It issues the oldest ready entry through a valid/ready handshake, and supports a full flush on misprediction.

## Interface
Parameters:
- DEPTH, 4: number of entries, power of two, ≥ 2
- CH, 4: number of broadcast channels (alu0..alu2, ls)
- XLEN, 32: data, pc and immediate width
- TAG_W, 4: register tag width
- OP_W, 6: sub-instruction opcode width
- UNLOCKED, 0: tag value meaning "operand value present"

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; 0 stalls allocation and issue (snooping continues)
- alloc_en  in  1  allocate one branch this cycle
- alloc_pc  in  XLEN  branch pc
- alloc_op  in  OP_W  branch sub-op
- alloc_imm  in  XLEN  branch offset
- alloc_tagx / alloc_tagy  in  TAG_W  operand tags
- alloc_datax / alloc_datay  in  XLEN  operand values (valid when tag == UNLOCKED)
- full  out  1  no free entry; allocator must not assert alloc_en
- count  out  clog2(DEPTH)+1  number of valid entries
- cdb_en  in  CH  per-channel broadcast valid
- cdb_tag  in  CH*TAG_W  packed tags, channel 0 in LSBs
- cdb_data  in  CH*XLEN  packed results, channel 0 in LSBs
- issue_valid  out  1  a ready entry is presented
- issue_ready  in  1  branch unit accepts it
- issue_pc, issue_imm, issue_datax, issue_datay  out  XLEN  fields of the presented entry
- issue_op  out  OP_W  sub-op of the presented entry
- flush  in  1  discard all entries

## Operation
- Per-entry state: valid, pc, op, imm, tagx, tagy, datax, datay, age (clog2(DEPTH) bits).
- An entry is ready when valid=1 and tagx == tagy == UNLOCKED.
- Wakeup, every cycle including rdy=0:
  - For each valid entry and each operand whose tag != UNLOCKED, compare against every channel with cdb_en=1.
  - On a match, write the data and set the tag to UNLOCKED.
  - If several channels match, the lowest channel index wins.
  - A tag equal to UNLOCKED never matches.
- Allocation (alloc_en & rdy & !full & !flush):
  - Write the lowest-index free entry with age=0.
  - Increment the age of every other valid entry that is not being issued this cycle.
  - Bypass: if an alloc tag matches an active channel in the same cycle, capture the cdb data and store the tag as UNLOCKED.
- Issue selection is combinational from registered state. issue_valid = rdy & (any ready entry). The presented entry is the ready entry with the largest age.
- Handshake: when issue_valid & issue_ready, the presented entry's valid bit clears at the edge.
  - Every valid entry younger than it keeps its age. Ages stay unique and dense.
  - issue_valid must not depend on issue_ready.
- Selection is dynamic: if an older entry becomes ready, it becomes the presented entry on the next cycle. This holds even while issue_valid is high and issue_ready is low.
- full = (count == DEPTH), computed from current state.
- Simultaneous issue and alloc while full: the alloc is refused.
- Simultaneous issue and alloc while not full: both occur, and count is unchanged.
- alloc_en while full is ignored with no state change.
- flush clears all valid bits and sets count to 0. flush has priority over alloc, issue and wakeup.

## Timing
- Reset:
  - All valid bits 0, tags UNLOCKED, data/pc/imm/op/age 0.
  - Outputs: full=0, count=0, issue_valid=0, all issue_* fields 0.
- Latency:
  - Alloc with both operands present or bypassed gives issue_valid in the next cycle (1 cycle).
  - A broadcast that wakes the last pending operand gives issue_valid in the next cycle.
- rst in mid-operation acts like flush and also zeroes all fields. rst has priority over everything.
- rdy=0:
  - issue_valid=0, and allocation is ignored.
  - Wakeups are still captured, so no broadcast is lost.
- Throughput: one alloc and one issue per cycle.

## Test plan
- Reset, then alloc pc=0x100 with both tags UNLOCKED, datax=5, datay=5, issue_ready=1 → next cycle issue_valid=1, issue_pc=0x100, issue_datax=5; the following cycle count=0.
- Alloc A (tagx=3) then B (ready), issue_ready=0 → B presented. Then cdb_en[1]=1, cdb_tag=3, data=0x77 → next cycle A presented (older), issue_datax=0x77.
- Fill 4 entries with pending tags → full=1, and a 5th alloc is ignored (count stays 4). Then issue one and alloc in the same cycle → refused, count=3.
- Alloc tagy=7 in the same cycle as cdb_en[2]=1, tag=7, data=0xABCD → entry ready the next cycle, issue_datay=0xABCD.
- Channels 0 and 3 both broadcast tag 2 with data 0x11 / 0x22 to a waiting entry → captured 0x11.
- 3 valid entries, flush asserted together with alloc_en → count=0, issue_valid=0, full=0. Also apply rst mid-stream → all outputs at their reset values the next cycle.
